frame_scheduler: RTL and testbench

- Per-frame controller for the DSP sequencer.
- On each audio frame strobe it advances the frame index, swaps coefficient banks when the host has asked for it, and pulses the sequencer out of reset.
- It then waits for the sequencer to halt, publishes a results-ready pulse and reports run length, overruns, timeouts and sequencer errors.
- Sits between the audio input writer / host register file and the sequencer.

---
 rtl/frame_sched_pkg.sv | 16 +
 rtl/frame_scheduler_run_counter.sv | 40 ++++
 rtl/frame_scheduler.sv | 174 +++++++++++++++++
 tb/tb_frame_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sched_pkg.sv
// Shared types and default sizing for the DSP frame scheduler.
// Imported by the scheduler FSM and its run counter.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int FRAME_W_DEF = 4;
  localparam int CNT_W_DEF   = 10;
  localparam int ARM_CYC_DEF = 2;
  localparam int MAX_CYC_DEF = 1000;

endpackage

// File: rtl/frame_scheduler_run_counter.sv
// Run-length counter with synchronous clear/enable.
// at_limit flags the last cycle a run may last.
module run_counter
  import frame_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int LIMIT = MAX_CYC_DEF - 1
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign at_limit = (count_q == CNT_W'(LIMIT));

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame sequencer controller: arms, runs and reports
// one sequencer pass per audio frame, with a one-deep frame queue.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int ARM_CYC = ARM_CYC_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MAX_CYC = MAX_CYC_DEF
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               frame_strobe,
  input  logic               seq_done,
  input  logic               seq_error,
  output logic               seq_run,
  output logic [FRAME_W-1:0] frame,
  input  logic               bank_swap_req,
  output logic               coef_bank,
  output logic               bank_swap_ack,
  output logic               out_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   run_cycles,
  output logic               overrun,
  output logic               timeout,
  output logic               error,
  input  logic               clear
);

  localparam int AW = (ARM_CYC > 2) ? $clog2(ARM_CYC) : 1;

  state_e state_d, state_q;
  logic [FRAME_W-1:0] frame_d, frame_q;
  logic [AW-1:0] arm_d, arm_q;
  logic [CNT_W-1:0] rc_d, rc_q;
  logic run_d, run_q;
  logic bank_d, bank_q;
  logic ack_d, ack_q;
  logic rdy_d, rdy_q;
  logic busy_d, busy_q;
  logic pf_d, pf_q;
  logic ps_d, ps_q;
  logic ovr_d, ovr_q;
  logic tmo_d, tmo_q;
  logic err_d, err_q;
  logic cnt_clr;
  logic [CNT_W-1:0] cnt;
  logic at_limit;

  run_counter #(
    .CNT_W (CNT_W),
    .LIMIT (MAX_CYC - 1)
  ) u_cnt (
    .ck       (ck),
    .rst      (rst),
    .clr      (cnt_clr),
    .en       (state_q == RUN),
    .count    (cnt),
    .at_limit (at_limit)
  );

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    arm_d   = arm_q;
    rc_d    = rc_q;
    run_d   = run_q;
    bank_d  = bank_q;
    ack_d   = 1'b0;
    rdy_d   = 1'b0;
    pf_d    = pf_q;
    ps_d    = ps_q | bank_swap_req;
    ovr_d   = ovr_q & ~clear;
    tmo_d   = tmo_q & ~clear;
    err_d   = err_q & ~clear;
    cnt_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_strobe || pf_q) begin
          frame_d = frame_q + 1'b1;
          if (ps_q || bank_swap_req) begin
            bank_d = ~bank_q;
            ack_d  = 1'b1;
            ps_d   = 1'b0;
          end
          // a strobe landing while a queued frame starts stays queued
          pf_d    = frame_strobe & pf_q;
          run_d   = 1'b0;
          arm_d   = AW'(ARM_CYC - 1);
          state_d = ARM;
        end
      end
      ARM: begin
        run_d = 1'b0;
        if (arm_q == '0) begin
          run_d   = 1'b1;
          cnt_clr = 1'b1;
          state_d = RUN;
        end else begin
          arm_d = arm_q - 1'b1;
        end
      end
      RUN: begin
        if (seq_done) begin
          rc_d    = cnt;
          rdy_d   = 1'b1;
          state_d = IDLE;
          if (seq_error) begin
            err_d = 1'b1;
          end
        end else if (at_limit) begin
          tmo_d   = 1'b1;
          run_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && frame_strobe) begin
      if (pf_q) begin
        ovr_d = 1'b1;
      end else begin
        pf_d = 1'b1;
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      arm_q   <= '0;
      rc_q    <= '0;
      run_q   <= 1'b0;
      bank_q  <= 1'b0;
      ack_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      pf_q    <= 1'b0;
      ps_q    <= 1'b0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      arm_q   <= arm_d;
      rc_q    <= rc_d;
      run_q   <= run_d;
      bank_q  <= bank_d;
      ack_q   <= ack_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      pf_q    <= pf_d;
      ps_q    <= ps_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign seq_run       = run_q;
  assign frame         = frame_q;
  assign coef_bank     = bank_q;
  assign bank_swap_ack = ack_q;
  assign out_ready     = rdy_q;
  assign busy          = busy_q;
  assign run_cycles    = rc_q;
  assign overrun       = ovr_q;
  assign timeout       = tmo_q;
  assign error         = err_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: timestamp-based reference
// model, sequencer responder, directed scenarios and random traffic.
module tb_frame_scheduler;

  localparam int FW   = 4;
  localparam int CW   = 10;
  localparam int ARMC = 2;
  localparam int MAXC = 1000;

  logic ck = 1'b0;
  logic rst = 1'b1;
  logic frame_strobe = 1'b0;
  logic seq_done = 1'b0;
  logic seq_error = 1'b0;
  logic bank_swap_req = 1'b0;
  logic clear = 1'b0;
  logic seq_run, coef_bank, bank_swap_ack, out_ready, busy;
  logic overrun, timeout, error;
  logic [FW-1:0] frame;
  logic [CW-1:0] run_cycles;

  frame_scheduler #(
    .FRAME_W (FW),
    .ARM_CYC (ARMC),
    .CNT_W   (CW),
    .MAX_CYC (MAXC)
  ) dut (
    .ck            (ck),
    .rst           (rst),
    .frame_strobe  (frame_strobe),
    .seq_done      (seq_done),
    .seq_error     (seq_error),
    .seq_run       (seq_run),
    .frame         (frame),
    .bank_swap_req (bank_swap_req),
    .coef_bank     (coef_bank),
    .bank_swap_ack (bank_swap_ack),
    .out_ready     (out_ready),
    .busy          (busy),
    .run_cycles    (run_cycles),
    .overrun       (overrun),
    .timeout       (timeout),
    .error         (error),
    .clear         (clear)
  );

  always #5 ck = ~ck;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  typedef struct {int at; int rc;} rdy_t;
  typedef struct {int at; bit bank;} ack_t;
  rdy_t rdy_q[$];
  ack_t ack_q[$];

  // reference model: a run is a set of timestamps from its accept edge
  int cyc = 0;
  int plan_d = 0;
  bit err_rand = 0;
  bit force_err = 0;
  bit m_active, m_pend, m_swap, m_held, m_bank;
  bit m_ovr, m_tmo, m_err;
  int m_frame, m_arm_end, m_done_at, last_rc;

  always @(posedge ck) begin : model
    bit sw;
    int k;
    cyc++;
    if (rst) begin
      m_active = 0; m_pend = 0; m_swap = 0; m_held = 0; m_bank = 0;
      m_ovr = 0; m_tmo = 0; m_err = 0; m_frame = 0; last_rc = 0;
    end else begin
      if (clear) begin
        m_ovr = 0; m_tmo = 0; m_err = 0;
      end
      sw = m_swap | bank_swap_req;
      m_swap = sw;
      if (!m_active) begin
        if (frame_strobe || m_pend) begin
          m_frame = (m_frame + 1) % (1 << FW);
          if (sw) begin
            m_bank = !m_bank;
            m_swap = 0;
            ack_q.push_back('{cyc, m_bank});
          end
          m_pend = frame_strobe && m_pend;
          m_active = 1;
          m_held = 0;
          m_arm_end = cyc + ARMC;
          m_done_at = m_arm_end + 1 + plan_d;
        end
      end else begin
        if (frame_strobe) begin
          if (m_pend) m_ovr = 1;
          else m_pend = 1;
        end
        if (cyc > m_arm_end) begin
          k = cyc - m_arm_end - 1;
          if (seq_done) begin
            if (seq_error) m_err = 1;
            last_rc = k;
            rdy_q.push_back('{cyc, k});
            m_active = 0;
            m_held = 1;
          end else if (k == MAXC - 1) begin
            m_tmo = 1;
            m_active = 0;
            m_held = 0;
          end
        end
      end
    end
  end

  // sequencer stand-in: halted whenever not armed/running by plan
  always @(posedge ck) begin
    #1;
    if (m_active)
      seq_done = (cyc + 1 > m_arm_end) && (cyc + 1 >= m_done_at);
    else
      seq_done = 1'b1;
    seq_error = force_err || (err_rand && $urandom_range(0, 3) == 0);
  end

  always @(negedge ck) begin
    logic [19:0] want_st;
    logic want_run;
    bit er, ea;
    rdy_t r;
    ack_t a;
    if (cyc >= 1) begin
      want_run = m_active ? (cyc >= m_arm_end) : m_held;
      want_st = {want_run, m_active, FW'(m_frame), m_bank,
                 m_ovr, m_tmo, m_err, CW'(last_rc)};
      check("state", {seq_run, busy, frame, coef_bank, overrun,
                      timeout, error, run_cycles}, want_st);
      er = rdy_q.size() > 0 && rdy_q[0].at == cyc;
      if (out_ready || er) begin
        check("out_ready", out_ready, er);
        if (er) begin
          r = rdy_q.pop_front();
          check("rdy_run_cycles", run_cycles, r.rc);
        end
      end
      ea = ack_q.size() > 0 && ack_q[0].at == cyc;
      if (bank_swap_ack || ea) begin
        check("bank_ack", bank_swap_ack, ea);
        if (ea) begin
          a = ack_q.pop_front();
          check("ack_bank", coef_bank, a.bank);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  task automatic run_one(input int d);
    plan_d = d;
    frame_strobe = 1'b1;
    step(1);
    frame_strobe = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy === 1'b1 && n < lim) begin
      step(1);
      n++;
    end
    check("idle_bound", busy, 1'b0);
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    check("rst_frame", frame, 0);
    check("rst_seq_run", seq_run, 0);
    step(5);

    // first run: accept, two arm cycles, 27-cycle run
    run_one(27);
    check("acc_frame", frame, 1);
    check("acc_seq_run", seq_run, 0);
    check("acc_busy", busy, 1);
    step(ARMC);
    check("arm_release", seq_run, 1);
    step(28);
    check("done_ready", out_ready, 1);
    check("done_rc", run_cycles, 27);
    check("done_busy", busy, 0);
    check("done_held", seq_run, 1);

    for (int i = 0; i < 15; i++) begin
      run_one(3 + i);
      check("frame_seq", frame, (i + 2) % 16);
      wait_idle(200);
    end
    check("frame_wrap", frame, 0);
    check("no_overrun", overrun, 0);

    run_one(40);
    step(ARMC + 5);
    frame_strobe = 1'b1;
    step(1);
    frame_strobe = 1'b0;
    check("pend_no_ovr", overrun, 0);
    step(3);
    plan_d = 10;
    frame_strobe = 1'b1;
    step(1);
    frame_strobe = 1'b0;
    check("ovr_set", overrun, 1);
    wait_idle(200);
    check("pend_ready", out_ready, 1);
    step(1);
    check("pend_restart", busy, 1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("ovr_clear", overrun, 0);
    wait_idle(200);

    run_one(30);
    step(4);
    bank_swap_req = 1'b1;
    step(1);
    bank_swap_req = 1'b0;
    step(2);
    bank_swap_req = 1'b1;
    step(1);
    bank_swap_req = 1'b0;
    check("bank_hold_run", coef_bank, 0);
    wait_idle(200);
    check("bank_hold_idle", coef_bank, 0);
    step(2);
    run_one(5);
    check("bank_toggle", coef_bank, 1);
    check("bank_ack_pulse", bank_swap_ack, 1);
    wait_idle(200);
    run_one(5);
    check("single_toggle", coef_bank, 1);
    check("single_ack", bank_swap_ack, 0);
    wait_idle(200);

    run_one(MAXC + 10);
    wait_idle(MAXC + 50);
    check("timeout_set", timeout, 1);
    check("timeout_run", seq_run, 0);
    force_err = 1'b1;
    run_one(8);
    wait_idle(200);
    force_err = 1'b0;
    check("error_set", error, 1);

    run_one(50);
    step(ARMC + 5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_run", seq_run, 0);
    check("mid_rst_frame", frame, 0);
    check("mid_rst_bank", coef_bank, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sticky", {timeout, error, overrun}, 0);
    step(3);

    err_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      frame_strobe  = ($urandom_range(0, 29) == 0);
      bank_swap_req = ($urandom_range(0, 39) == 0);
      clear         = ($urandom_range(0, 59) == 0);
      plan_d        = $urandom_range(0, 60);
      step(1);
    end
    frame_strobe = 1'b0;
    bank_swap_req = 1'b0;
    clear = 1'b0;
    wait_idle(300);
    step(1);
    wait_idle(300);
    step(2);
    check("sb_drain", rdy_q.size() + ack_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
